// File: rtl/sync_frame_fifo_pkg.sv
// Shared defaults and helpers for the frame-aware synchronous FIFO.
package sync_frame_fifo_pkg;

  localparam int DEF_WD         = 8;
  localparam int DEF_WA         = 13;
  localparam int DEF_AEMPTY_CNT = 1514;
  localparam int DEF_AFULL_CNT  = 6660;
  localparam int DEF_FCW        = 8;

  function automatic int depth_of(input int wa);
    return 1 << wa;
  endfunction

  localparam int DEF_DEPTH = depth_of(DEF_WA);

endpackage

// File: rtl/sync_frame_fifo_ram.sv
// Single-clock simple dual-port RAM with a registered, resettable read port.
module sdp_ram #(
  parameter int W = 9,
  parameter int A = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [0:(1<<A)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_frame_fifo.sv
// Store-and-forward frame FIFO: words become readable only once their frame's
// EOD word has been written; aborted or overflowed frames are rolled back.
module sync_frame_fifo
  import sync_frame_fifo_pkg::*;
#(
  parameter int WD         = DEF_WD,
  parameter int WA         = DEF_WA,
  parameter int AEMPTY_CNT = DEF_AEMPTY_CNT,
  parameter int AFULL_CNT  = DEF_AFULL_CNT,
  parameter int FCW        = DEF_FCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WD-1:0]  di,
  input  logic           we,
  input  logic           EOD_in,
  input  logic           abort,
  input  logic           re,
  output logic [WD-1:0]  dout,
  output logic           EOD_out,
  output logic           empty_flag,
  output logic           aempty_flag,
  output logic           full_flag,
  output logic           afull_flag,
  output logic           frame_exist,
  output logic [FCW-1:0] frame_cnt,
  output logic [WA:0]    level,
  output logic           drop
);

  localparam int             DEPTH    = depth_of(WA);
  localparam logic [WA:0]    DEPTH_W  = (WA+1)'(DEPTH);
  localparam logic [WA:0]    AEMPTY_W = (WA+1)'(AEMPTY_CNT);
  localparam logic [WA:0]    AFULL_W  = (WA+1)'(AFULL_CNT);
  localparam logic [WA:0]    PTR_ONE  = (WA+1)'(1);
  localparam logic [FCW-1:0] CNT_MAX  = '1;

  logic [WA:0]    wptr, cptr, rptr, used;
  logic [WD:0]    rd_word;
  logic [FCW-1:0] cnt_reg;
  logic           ovf, rd_pend, eod_pend;
  logic           frame_block, ovf_hit, wr_ok, rd_ok, commit;

  assign used        = wptr - rptr;
  assign level       = cptr - rptr;
  assign empty_flag  = (rptr == cptr);
  assign full_flag   = (used == DEPTH_W);
  assign aempty_flag = (level <= AEMPTY_W);
  assign afull_flag  = (used >= AFULL_W);

  // The EOD word just presented on dout is subtracted immediately so the count
  // drops in the same cycle the frame's last word appears.
  assign eod_pend    = rd_pend & rd_word[WD];
  assign frame_cnt   = cnt_reg - FCW'(eod_pend);
  assign frame_exist = (frame_cnt != '0);

  assign frame_block = (wptr == cptr) & (frame_cnt == CNT_MAX);
  assign ovf_hit     = we & ~abort & (ovf | (full_flag & ~frame_block));
  assign wr_ok       = we & ~abort & ~ovf & ~full_flag & ~frame_block;
  assign commit      = wr_ok & EOD_in;
  assign rd_ok       = re & ~empty_flag;

  assign dout    = rd_word[WD-1:0];
  assign EOD_out = rd_word[WD];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      cptr    <= '0;
      rptr    <= '0;
      ovf     <= 1'b0;
      drop    <= 1'b0;
      rd_pend <= 1'b0;
      cnt_reg <= '0;
    end else begin
      drop <= 1'b0;
      // An overflowed frame is held in ovf until its EOD, then discarded.
      if (abort | (ovf_hit & EOD_in)) begin
        wptr <= cptr;
        ovf  <= 1'b0;
        drop <= 1'b1;
      end else if (ovf_hit) begin
        ovf <= 1'b1;
      end else if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
        if (EOD_in) cptr <= wptr + PTR_ONE;
      end
      if (rd_ok) rptr <= rptr + PTR_ONE;
      rd_pend <= rd_ok;
      cnt_reg <= cnt_reg + FCW'(commit) - FCW'(eod_pend);
    end
  end

  sdp_ram #(
    .W(WD + 1),
    .A(WA)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr[WA-1:0]),
    .wdata ({EOD_in, di}),
    .re    (rd_ok),
    .raddr (rptr[WA-1:0]),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_sync_frame_fifo.sv
// Scoreboard bench for sync_frame_fifo using a small 128-word configuration.
module tb_sync_frame_fifo;
  import sync_frame_fifo_pkg::*;

  localparam int WD     = 8;
  localparam int WA     = 7;
  localparam int DEPTH  = 128;
  localparam int AEMPTY = 8;
  localparam int AFULL  = 120;
  localparam int FCW    = 3;
  localparam int FC_MAX = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic [WD-1:0]  di;
  logic           we, EOD_in, abort, re;
  logic [WD-1:0]  dout;
  logic           EOD_out, empty_flag, aempty_flag, full_flag, afull_flag;
  logic           frame_exist, drop;
  logic [FCW-1:0] frame_cnt;
  logic [WA:0]    level;

  logic [WD:0] commit_q[$];
  logic [WD:0] part_q[$];
  logic [WD:0] exp_rd;
  bit          rd_fired, m_ovf, m_drop;
  int          m_fc;
  int          errors = 0;
  int          checks = 0;

  sync_frame_fifo #(
    .WD(WD), .WA(WA), .AEMPTY_CNT(AEMPTY), .AFULL_CNT(AFULL), .FCW(FCW)
  ) dut (
    .clk(clk), .rst(rst), .di(di), .we(we), .EOD_in(EOD_in), .abort(abort), .re(re),
    .dout(dout), .EOD_out(EOD_out), .empty_flag(empty_flag), .aempty_flag(aempty_flag),
    .full_flag(full_flag), .afull_flag(afull_flag), .frame_exist(frame_exist),
    .frame_cnt(frame_cnt), .level(level), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    commit_q.delete();
    part_q.delete();
    exp_rd   = '0;
    rd_fired = 1'b0;
    m_ovf    = 1'b0;
    m_drop   = 1'b0;
    m_fc     = 0;
  endtask

  // One clock of stimulus; the model is advanced from the pre-edge state.
  task automatic step(input bit w, input logic [WD-1:0] d, input bit e, input bit a, input bit r);
    int occ;
    bit m_full, m_block;
    we = w; di = d; EOD_in = e; abort = a; re = r;
    occ      = commit_q.size() + part_q.size();
    m_full   = (occ == DEPTH);
    m_block  = (part_q.size() == 0) && (m_fc == FC_MAX);
    m_drop   = 1'b0;
    rd_fired = 1'b0;
    if (r && commit_q.size() != 0) begin
      exp_rd   = commit_q.pop_front();
      rd_fired = 1'b1;
    end
    if (a) begin
      part_q.delete(); m_ovf = 1'b0; m_drop = 1'b1;
    end else if (w && (m_ovf || (m_full && !m_block))) begin
      if (e) begin part_q.delete(); m_ovf = 1'b0; m_drop = 1'b1; end
      else m_ovf = 1'b1;
    end else if (w && !m_full && !m_block) begin
      part_q.push_back({e, d});
      if (e) begin
        while (part_q.size() != 0) commit_q.push_back(part_q.pop_front());
        m_fc++;
      end
    end
    if (rd_fired && exp_rd[WD]) m_fc--;
    @(posedge clk);
    #1;
    we = 1'b0; di = '0; EOD_in = 1'b0; abort = 1'b0; re = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 0; di = '0; EOD_in = 0; abort = 0; re = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({empty_flag, aempty_flag, full_flag, afull_flag, frame_exist, drop} !== 6'b110000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 110000", {empty_flag, aempty_flag, full_flag, afull_flag, frame_exist, drop}); end
    checks++; if ({EOD_out, dout} !== 9'h000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000", {EOD_out, dout}); end
    checks++; if (level !== 8'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++; if (frame_cnt !== 3'd0) begin errors++; $display("[TB] FAIL reset_fcnt: got %0d expected 0", frame_cnt); end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_frame_write();
    for (int i = 0; i < 63; i++) begin
      step(1, WD'($urandom), 0, 0, 0);
      checks++; if (empty_flag !== 1'b1) begin errors++; $display("[TB] FAIL fw_empty_early: word %0d got %b expected 1", i, empty_flag); end
    end
    step(1, WD'($urandom), 1, 0, 0);
    checks++; if (empty_flag !== 1'b0) begin errors++; $display("[TB] FAIL fw_empty_after: got %b expected 0", empty_flag); end
    checks++; if (level !== 8'd64) begin errors++; $display("[TB] FAIL fw_level: got %0d expected 64", level); end
    checks++; if (frame_cnt !== 3'd1 || frame_exist !== 1'b1) begin errors++; $display("[TB] FAIL fw_fcnt: got %0d/%b expected 1/1", frame_cnt, frame_exist); end
    for (int i = 0; i < 64; i++) begin
      step(0, '0, 0, 0, 1);
      checks++; if (!rd_fired || {EOD_out, dout} !== exp_rd) begin errors++; $display("[TB] FAIL fw_data: read %0d got %h expected %h", i, {EOD_out, dout}, exp_rd); end
      checks++; if (aempty_flag !== (commit_q.size() <= AEMPTY)) begin errors++; $display("[TB] FAIL fw_aempty: level %0d got %b", commit_q.size(), aempty_flag); end
    end
    checks++; if (frame_cnt !== 3'd0 || empty_flag !== 1'b1) begin errors++; $display("[TB] FAIL fw_drained: got fcnt %0d empty %b expected 0/1", frame_cnt, empty_flag); end
  endtask

  task automatic test_read_frame();
    for (int i = 0; i < 3; i++) step(1, WD'(8'hA0 + i), (i == 2), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, 0, 1);
      checks++; if ({EOD_out, dout} !== {(i == 2), WD'(8'hA0 + i)}) begin errors++; $display("[TB] FAIL rd_word: %0d got %h expected %h", i, {EOD_out, dout}, {(i == 2), WD'(8'hA0 + i)}); end
      checks++; if (frame_cnt !== FCW'(m_fc) || m_fc != (i == 2 ? 0 : 1)) begin errors++; $display("[TB] FAIL rd_fcnt: %0d got %0d expected %0d", i, frame_cnt, (i == 2 ? 0 : 1)); end
    end
    step(0, '0, 0, 0, 1);
    checks++; if ({EOD_out, dout} !== {1'b1, WD'(8'hA2)}) begin errors++; $display("[TB] FAIL rd_hold: got %h expected 1a2", {EOD_out, dout}); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 10; i++) step(1, WD'($urandom), 0, 0, 0);
    step(0, '0, 0, 1, 0);
    checks++; if (drop !== 1'b1 || level !== 8'd0 || empty_flag !== 1'b1) begin errors++; $display("[TB] FAIL abort_pulse: got drop %b level %0d empty %b expected 1/0/1", drop, level, empty_flag); end
    step(0, '0, 0, 0, 0);
    checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL abort_width: got %b expected 0", drop); end
    step(1, 8'hEE, 1, 1, 0);
    checks++; if (drop !== 1'b1 || level !== 8'd0) begin errors++; $display("[TB] FAIL abort_wins: got drop %b level %0d expected 1/0", drop, level); end
    for (int i = 0; i < 3; i++) step(1, WD'(8'h50 + i), (i == 2), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, 0, 1);
      checks++; if (!rd_fired || {EOD_out, dout} !== exp_rd) begin errors++; $display("[TB] FAIL abort_next: %0d got %h expected %h", i, {EOD_out, dout}, exp_rd); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 40; i++) step(1, WD'($urandom), (i == 39), 0, 0);
    for (int i = 0; i < 88; i++) begin
      step(1, WD'($urandom), 0, 0, 0);
      checks++; if (afull_flag !== ((commit_q.size() + part_q.size()) >= AFULL)) begin errors++; $display("[TB] FAIL ovf_afull: used %0d got %b", commit_q.size() + part_q.size(), afull_flag); end
    end
    checks++; if (full_flag !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full: got %b expected 1", full_flag); end
    for (int i = 0; i < 5; i++) begin
      step(1, WD'($urandom), 0, 0, (i == 0));
      checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early_drop: %0d got %b expected 0", i, drop); end
      if (rd_fired) begin
        checks++; if ({EOD_out, dout} !== exp_rd) begin errors++; $display("[TB] FAIL ovf_rd: got %h expected %h", {EOD_out, dout}, exp_rd); end
      end
    end
    step(1, WD'($urandom), 1, 0, 0);
    checks++; if (drop !== 1'b1 || full_flag !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drop: got drop %b full %b expected 1/0", drop, full_flag); end
    checks++; if (level !== 8'd39 || frame_cnt !== 3'd1) begin errors++; $display("[TB] FAIL ovf_keep: got level %0d fcnt %0d expected 39/1", level, frame_cnt); end
    for (int i = 0; i < 39; i++) begin
      step(0, '0, 0, 0, 1);
      checks++; if (!rd_fired || {EOD_out, dout} !== exp_rd) begin errors++; $display("[TB] FAIL ovf_intact: %0d got %h expected %h", i, {EOD_out, dout}, exp_rd); end
    end
    checks++; if (empty_flag !== 1'b1 || frame_cnt !== 3'd0) begin errors++; $display("[TB] FAIL ovf_end: got empty %b fcnt %0d expected 1/0", empty_flag, frame_cnt); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, WD'(8'h10 + i), (i % 2 == 1), 0, 0);
    step(1, 8'h20, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    checks++; if (frame_cnt !== 3'd2) begin errors++; $display("[TB] FAIL same_pre: got %0d expected 2", frame_cnt); end
    step(1, 8'h21, 1, 0, 1);
    checks++; if (frame_cnt !== 3'd2 || {EOD_out, dout} !== 9'h111) begin errors++; $display("[TB] FAIL same_cycle: got fcnt %0d word %h expected 2/111", frame_cnt, {EOD_out, dout}); end
    step(0, '0, 0, 0, 0);
    checks++; if (frame_cnt !== 3'd2) begin errors++; $display("[TB] FAIL same_post: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < FC_MAX; i++) step(1, WD'(8'h30 + i), 1, 0, 0);
    step(1, 8'h3F, 1, 0, 0);
    checks++; if (frame_cnt !== 3'd7 || level !== 8'd7 || drop !== 1'b0) begin errors++; $display("[TB] FAIL sat_block: got fcnt %0d level %0d drop %b expected 7/7/0", frame_cnt, level, drop); end
    step(0, '0, 0, 0, 1);
    checks++; if (frame_cnt !== 3'd6 || {EOD_out, dout} !== 9'h130) begin errors++; $display("[TB] FAIL sat_read: got fcnt %0d word %h expected 6/130", frame_cnt, {EOD_out, dout}); end
    step(1, 8'h3E, 1, 0, 0);
    checks++; if (frame_cnt !== 3'd7 || level !== 8'd7) begin errors++; $display("[TB] FAIL sat_resume: got fcnt %0d level %0d expected 7/7", frame_cnt, level); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, WD'($urandom), 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (drop !== 1'b0 || empty_flag !== 1'b1 || level !== 8'd0) begin errors++; $display("[TB] FAIL midrst: got drop %b empty %b level %0d expected 0/1/0", drop, empty_flag, level); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    step(1, 8'h77, 0, 0, 0);
    step(1, 8'h78, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, '0, 0, 0, 1);
      checks++; if (!rd_fired || {EOD_out, dout} !== exp_rd) begin errors++; $display("[TB] FAIL midrst_data: %0d got %h expected %h", i, {EOD_out, dout}, exp_rd); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 3 * DEPTH + 20; n++) begin
      step((n < 3 * DEPTH), WD'(n), (n % 16 == 15), 0, 1);
      checks++; if (level !== (WA+1)'(commit_q.size())) begin errors++; $display("[TB] FAIL wrap_level: step %0d got %0d expected %0d", n, level, commit_q.size()); end
      if (rd_fired) begin
        checks++; if ({EOD_out, dout} !== exp_rd) begin errors++; $display("[TB] FAIL wrap_data: step %0d got %h expected %h", n, {EOD_out, dout}, exp_rd); end
      end
    end
    checks++; if (empty_flag !== 1'b1 || frame_cnt !== 3'd0) begin errors++; $display("[TB] FAIL wrap_end: got empty %b fcnt %0d expected 1/0", empty_flag, frame_cnt); end
  endtask

  initial begin
    $display("[TB] package default depth %0d, bench depth %0d", DEF_DEPTH, DEPTH);
    rst = 1'b1; we = 0; di = '0; EOD_in = 0; abort = 0; re = 0;
    test_reset();
    test_frame_write();
    test_read_frame();
    test_abort();
    test_overflow();
    test_same_cycle();
    test_saturate();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
